// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the 1W/2R register-file RAM controller.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    SCRUB   = 2'd2,
    DONE    = 2'd3
  } host_state_e;

  // Read latency of the RAM as seen from the cycle its read enable is high.
  function automatic int unsigned lat(input int unsigned pipelined);
    return 1 + pipelined;
  endfunction

endpackage

// File: rtl/ram_rd_valid_pipe.sv
// Valid shift register that tracks hardware-port reads through the RAM latency.
module ram_rd_valid_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic res_n,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] stage_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) stage_q[0] <= 1'b0;
    else        stage_q[0] <= valid_i;
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) stage_q[gi] <= 1'b0;
      else        stage_q[gi] <= stage_q[gi-1];
    end
  end

  assign valid_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_1w2r_ctrl.sv
// Initiator-side controller for the 1W/2R register-file RAM: host FSM with
// latency tracking and scrubbing, hardware read path, saturating ECC statistics.
module ram_1w2r_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATASIZE  = 18,
  parameter int unsigned ADDRSIZE  = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned PIPELINED = 0,
  parameter int unsigned SCRUB_EN  = 1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [ADDRSIZE-1:0]  host_addr,
  input  logic                 host_ren,
  input  logic                 host_wen,
  input  logic [DATASIZE-1:0]  host_wdata,
  output logic [DATASIZE-1:0]  host_rdata,
  output logic                 host_access_complete,
  output logic                 host_invalid,
  input  logic                 hw_ren,
  input  logic [ADDRSIZE-1:0]  hw_addr,
  output logic [DATASIZE-1:0]  hw_rdata,
  output logic                 hw_rvalid,
  output logic                 ram_wen,
  output logic [ADDRSIZE-1:0]  ram_waddr,
  output logic [DATASIZE-1:0]  ram_wdata,
  output logic                 ram_ren1,
  output logic [ADDRSIZE-1:0]  ram_raddr1,
  input  logic [DATASIZE-1:0]  ram_rdata1,
  output logic                 ram_ren2,
  output logic [ADDRSIZE-1:0]  ram_raddr2,
  input  logic [DATASIZE-1:0]  ram_rdata2,
  input  logic                 ram_sec,
  input  logic                 ram_ded,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] sec_count,
  output logic [CNT_WIDTH-1:0] ded_count,
  output logic                 ded_flag
);

  localparam int unsigned L   = lat(PIPELINED);
  localparam int unsigned LCW = $clog2(L + 1);
  localparam logic [ADDRSIZE:0] DEPTH_LIM = (ADDRSIZE+1)'(MEM_DEPTH);

  host_state_e          state_q;
  logic [LCW-1:0]       lat_cnt_q;
  logic [ADDRSIZE-1:0]  addr_q;
  logic [DATASIZE-1:0]  rdata_q;
  logic                 complete_q;
  logic                 invalid_q;
  logic                 ram_wen_q;
  logic [ADDRSIZE-1:0]  ram_waddr_q;
  logic [DATASIZE-1:0]  ram_wdata_q;
  logic                 ram_ren1_q;
  logic [ADDRSIZE-1:0]  ram_raddr1_q;
  logic                 ram_ren2_q;
  logic [ADDRSIZE-1:0]  ram_raddr2_q;
  logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;
  logic                 ded_flag_q, ded_flag_d;

  logic req_invalid;
  logic rd_done;
  logic sec_evt;
  logic ded_evt;
  logic scrub_needed;

  assign req_invalid  = (host_ren && host_wen) || ({1'b0, host_addr} >= DEPTH_LIM);
  // Port-1 data and its error flags are valid in the last RD_WAIT cycle.
  assign rd_done      = (state_q == RD_WAIT) && (lat_cnt_q == '0);
  assign ded_evt      = rd_done && ram_ded;
  assign sec_evt      = rd_done && ram_sec && !ram_ded;
  assign scrub_needed = sec_evt && (SCRUB_EN != 0);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      complete_q   <= 1'b0;
      invalid_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      ram_ren1_q   <= 1'b0;
      ram_raddr1_q <= '0;
    end else begin
      complete_q <= 1'b0;
      invalid_q  <= 1'b0;
      ram_wen_q  <= 1'b0;
      ram_ren1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_ren || host_wen) begin
            addr_q <= host_addr;
            if (req_invalid) begin
              complete_q <= 1'b1;
              invalid_q  <= 1'b1;
              rdata_q    <= '0;
              state_q    <= DONE;
            end else if (host_wen) begin
              ram_wen_q   <= 1'b1;
              ram_waddr_q <= host_addr;
              ram_wdata_q <= host_wdata;
              complete_q  <= 1'b1;
              rdata_q     <= '0;
              state_q     <= DONE;
            end else begin
              ram_ren1_q   <= 1'b1;
              ram_raddr1_q <= host_addr;
              lat_cnt_q    <= LCW'(L);
              state_q      <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (!rd_done) begin
            lat_cnt_q <= lat_cnt_q - LCW'(1);
          end else begin
            rdata_q <= ram_rdata1;
            if (scrub_needed) begin
              // Write the corrected word back before completing the read.
              ram_wen_q   <= 1'b1;
              ram_waddr_q <= addr_q;
              ram_wdata_q <= ram_rdata1;
              state_q     <= SCRUB;
            end else begin
              complete_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        SCRUB: begin
          complete_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ram_ren2_q   <= 1'b0;
      ram_raddr2_q <= '0;
    end else begin
      ram_ren2_q   <= hw_ren;
      ram_raddr2_q <= hw_addr;
    end
  end

  ram_rd_valid_pipe #(
    .DEPTH (L + 1)
  ) u_hw_valid_pipe (
    .clk     (clk),
    .res_n   (res_n),
    .valid_i (hw_ren),
    .valid_o (hw_rvalid)
  );

  // Clear is applied first so an event in the same cycle is counted afterwards.
  always_comb begin
    sec_cnt_d  = sec_cnt_q;
    ded_cnt_d  = ded_cnt_q;
    ded_flag_d = ded_flag_q;
    if (cnt_clear) begin
      sec_cnt_d  = '0;
      ded_cnt_d  = '0;
      ded_flag_d = 1'b0;
    end
    if (sec_evt && (sec_cnt_d != '1)) sec_cnt_d = sec_cnt_d + CNT_WIDTH'(1);
    if (ded_evt && (ded_cnt_d != '1)) ded_cnt_d = ded_cnt_d + CNT_WIDTH'(1);
    if (ded_evt) ded_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      ded_flag_q <= 1'b0;
    end else begin
      sec_cnt_q  <= sec_cnt_d;
      ded_cnt_q  <= ded_cnt_d;
      ded_flag_q <= ded_flag_d;
    end
  end

  assign host_rdata           = rdata_q;
  assign host_access_complete = complete_q;
  assign host_invalid         = invalid_q;
  assign hw_rdata             = ram_rdata2;
  assign ram_wen              = ram_wen_q;
  assign ram_waddr            = ram_waddr_q;
  assign ram_wdata            = ram_wdata_q;
  assign ram_ren1             = ram_ren1_q;
  assign ram_raddr1           = ram_raddr1_q;
  assign ram_ren2             = ram_ren2_q;
  assign ram_raddr2           = ram_raddr2_q;
  assign sec_count            = sec_cnt_q;
  assign ded_count            = ded_cnt_q;
  assign ded_flag             = ded_flag_q;

endmodule
